// File: rtl/mac_dot.sv
// mac_dot: two-stage pipelined multiply-accumulate producing one dot product every DOT_LEN
// valid terms. Stage 1 registers a*b, stage 2 accumulates and publishes the completed result.
// Optional feature macro MAC_SAT_EN: when defined, the accumulator saturates on overflow
// instead of wrapping modulo 2^ACC_W.
module mac_dot #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned SIGNED  = 0,
    parameter int unsigned DOT_LEN = 16
) (
    input  logic                  sys_clock,
    input  logic                  rst_n,
    input  logic                  sclr,
    input  logic                  in_valid,
    input  logic                  load,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product,
    output logic [ACC_W-1:0]      sum,
    output logic [ACC_W-1:0]      mac_out,
    output logic                  out_valid,
    output logic                  ovf
);

    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DOT_LEN + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DOT_LEN);

    if (ACC_W < PW) begin : g_bad_acc_w
        $error("mac_dot: ACC_W must be >= 2*DATA_W");
    end
    if (DOT_LEN < 1) begin : g_bad_dot_len
        $error("mac_dot: DOT_LEN must be >= 1");
    end

    logic [PW-1:0]    product_q, product_d;
    logic             v1_q, v1_d;
    logic             ld1_q, ld1_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rovf_q, rovf_d;
    logic [ACC_W-1:0] mac_q, mac_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [PW-1:0]    a_x, b_x, mul;
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] add_res;
    logic [ACC_W-1:0] add_val;
    logic             add_ovf;
`ifdef MAC_SAT_EN
    logic [ACC_W-1:0] sat_val;
`endif

    // Operand extension and multiply; low PW bits are exact for both signed and unsigned.
    always_comb begin
        a_x = {{DATA_W{(SIGNED != 0) & a[DATA_W-1]}}, a};
        b_x = {{DATA_W{(SIGNED != 0) & b[DATA_W-1]}}, b};
        mul = a_x * b_x;
    end

    // Widen the registered product to accumulator width, adding the overflow check.
    always_comb begin
        ext = '0;
        ext[PW-1:0] = product_q;
        for (int i = PW; i < ACC_W; i++) begin
            ext[i] = (SIGNED != 0) & product_q[PW-1];
        end
        add_full = {1'b0, acc_q} + {1'b0, ext};
        add_res  = add_full[ACC_W-1:0];
        if (SIGNED != 0) begin
            add_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (add_res[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            add_ovf = add_full[ACC_W];
        end
`ifdef MAC_SAT_EN
        // Signed overflow direction follows the common operand sign.
        if (SIGNED != 0) begin
            sat_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_val = '1;
        end
        add_val = add_ovf ? sat_val : add_res;
`else
        add_val = add_res;
`endif
    end

    // Pipeline next-state: sclr wins, then stage-1 capture and stage-2 accumulate/complete.
    always_comb begin
        product_d   = product_q;
        v1_d        = 1'b0;
        ld1_d       = 1'b0;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rovf_d      = rovf_q;
        mac_d       = mac_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (sclr) begin
            product_d = '0;
            acc_d     = '0;
            cnt_d     = '0;
            rovf_d    = 1'b0;
            mac_d     = '0;
            ovf_d     = 1'b0;
        end else begin
            if (in_valid) begin
                product_d = mul;
                v1_d      = 1'b1;
                ld1_d     = load;
            end
            if (v1_q) begin
                if (ld1_q || cnt_q == '0) begin
                    acc_d  = ext;
                    cnt_d  = CNT_W'(1);
                    rovf_d = 1'b0;
                end else begin
                    acc_d  = add_val;
                    cnt_d  = cnt_q + CNT_W'(1);
                    rovf_d = rovf_q | add_ovf;
                end
                if (cnt_d == CntLast) begin
                    mac_d       = acc_d;
                    ovf_d       = rovf_d;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clock or negedge rst_n) begin
        if (!rst_n) begin
            product_q   <= '0;
            v1_q        <= 1'b0;
            ld1_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rovf_q      <= 1'b0;
            mac_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            v1_q        <= v1_d;
            ld1_q       <= ld1_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rovf_q      <= rovf_d;
            mac_q       <= mac_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign product   = product_q;
    assign sum       = acc_q;
    assign mac_out   = mac_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_dot.sv
// tb_mac_dot: five mac_dot configurations share one input stream; each is compared every
// cycle with an integer-arithmetic model, plus directed checks of known results.
module tb_mac_dot;

    localparam int NI = 5;
    // Configurations: widths, signedness and dot length per instance.
    int cfg_aw[NI]  = '{12, 8, 12, 8, 8};
    int cfg_sg[NI]  = '{0, 0, 1, 1, 0};
    int cfg_len[NI] = '{4, 2, 4, 3, 1};

    logic       sys_clock = 1'b0;
    logic       rst_n     = 1'b1;
    logic       sclr      = 1'b0;
    logic       in_valid  = 1'b0;
    logic       load      = 1'b0;
    logic [3:0] a         = '0;
    logic [3:0] b         = '0;

    logic [7:0]  p0, p1, p2, p3, p4;
    logic [11:0] s0, m0, s2, m2;
    logic [7:0]  s1, m1, s3, m3, s4, m4;
    logic        v0, v1, v2, v3, v4;
    logic        o0, o1, o2, o3, o4;

    int n_checks = 0;
    int n_errors = 0;

    longint m_prod[NI], m_acc[NI], m_mac[NI];
    int     m_cnt[NI];
    bit     m_v1[NI], m_ld1[NI], m_rovf[NI], m_ovf[NI], m_ov[NI];

    always #5 sys_clock = ~sys_clock;

    mac_dot #(.DATA_W(4), .ACC_W(12), .SIGNED(0), .DOT_LEN(4)) u_d0 (
        .sys_clock(sys_clock), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .load(load),
        .a(a), .b(b), .product(p0), .sum(s0), .mac_out(m0), .out_valid(v0), .ovf(o0));
    mac_dot #(.DATA_W(4), .ACC_W(8), .SIGNED(0), .DOT_LEN(2)) u_d1 (
        .sys_clock(sys_clock), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .load(load),
        .a(a), .b(b), .product(p1), .sum(s1), .mac_out(m1), .out_valid(v1), .ovf(o1));
    mac_dot #(.DATA_W(4), .ACC_W(12), .SIGNED(1), .DOT_LEN(4)) u_d2 (
        .sys_clock(sys_clock), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .load(load),
        .a(a), .b(b), .product(p2), .sum(s2), .mac_out(m2), .out_valid(v2), .ovf(o2));
    mac_dot #(.DATA_W(4), .ACC_W(8), .SIGNED(1), .DOT_LEN(3)) u_d3 (
        .sys_clock(sys_clock), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .load(load),
        .a(a), .b(b), .product(p3), .sum(s3), .mac_out(m3), .out_valid(v3), .ovf(o3));
    mac_dot #(.DATA_W(4), .ACC_W(8), .SIGNED(0), .DOT_LEN(1)) u_d4 (
        .sys_clock(sys_clock), .rst_n(rst_n), .sclr(sclr), .in_valid(in_valid), .load(load),
        .a(a), .b(b), .product(p4), .sum(s4), .mac_out(m4), .out_valid(v4), .ovf(o4));

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint opv(input int i, input logic [3:0] x);
        if (cfg_sg[i] != 0 && x[3]) return longint'(x) - 16;
        return longint'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_prod[i] = 0; m_acc[i] = 0; m_mac[i] = 0; m_cnt[i] = 0;
            m_v1[i] = 0; m_ld1[i] = 0; m_rovf[i] = 0; m_ovf[i] = 0; m_ov[i] = 0;
        end
    endtask

    // One clock edge of the reference: true-valued sums, range checked against ACC_W.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            longint lo, hi, t, span;
            span = longint'(1) << cfg_aw[i];
            if (cfg_sg[i] != 0) begin
                hi = (span / 2) - 1;
                lo = -(span / 2);
            end else begin
                hi = span - 1;
                lo = 0;
            end
            m_ov[i] = 0;
            if (sclr) begin
                m_prod[i] = 0; m_acc[i] = 0; m_mac[i] = 0; m_cnt[i] = 0;
                m_v1[i] = 0; m_ld1[i] = 0; m_rovf[i] = 0; m_ovf[i] = 0;
            end else begin
                if (m_v1[i]) begin
                    if (m_ld1[i] || m_cnt[i] == 0) begin
                        m_acc[i] = m_prod[i];
                        m_cnt[i] = 1;
                        m_rovf[i] = 0;
                    end else begin
                        t = m_acc[i] + m_prod[i];
                        if (t > hi || t < lo) begin
                            m_rovf[i] = 1;
`ifdef MAC_SAT_EN
                            t = (t > hi) ? hi : lo;
`else
                            t = t & (span - 1);
                            if (t > hi) t = t - span;
`endif
                        end
                        m_acc[i] = t;
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                    if (m_cnt[i] == cfg_len[i]) begin
                        m_mac[i] = m_acc[i];
                        m_ovf[i] = m_rovf[i];
                        m_ov[i]  = 1;
                        m_cnt[i] = 0;
                    end
                end
                m_v1[i] = in_valid;
                if (in_valid) begin
                    m_prod[i] = opv(i, a) * opv(i, b);
                    m_ld1[i]  = load;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input longint p, input longint s, input longint m,
                              input longint v, input longint o);
        longint mask;
        mask = (longint'(1) << cfg_aw[i]) - 1;
        check($sformatf("prod%0d", i), p, m_prod[i] & 255);
        check($sformatf("sum%0d", i), s, m_acc[i] & mask);
        check($sformatf("mac%0d", i), m, m_mac[i] & mask);
        check($sformatf("oval%0d", i), v, longint'(m_ov[i]));
        check($sformatf("ovf%0d", i), o, longint'(m_ovf[i]));
    endtask

    task automatic check_model();
        check_inst(0, longint'(p0), longint'(s0), longint'(m0), longint'(v0), longint'(o0));
        check_inst(1, longint'(p1), longint'(s1), longint'(m1), longint'(v1), longint'(o1));
        check_inst(2, longint'(p2), longint'(s2), longint'(m2), longint'(v2), longint'(o2));
        check_inst(3, longint'(p3), longint'(s3), longint'(m3), longint'(v3), longint'(o3));
        check_inst(4, longint'(p4), longint'(s4), longint'(m4), longint'(v4), longint'(o4));
    endtask

    task automatic drive(input bit v, input bit l, input bit s, input logic [3:0] aa,
                         input logic [3:0] bb);
        in_valid = v; load = l; sclr = s; a = aa; b = bb;
        @(posedge sys_clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
    endtask

    initial begin
        int pulses;
        // Asynchronous reset with random inputs.
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1; load = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
        #2;
        model_reset();
        check_model();
        check("rst_sum0", longint'(s0), 0);
        check("rst_mac0", longint'(m0), 0);
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        rst_n = 1'b1;
        repeat (3) idle();
        check("idle_prod0", longint'(p0), 0);

        // Four terms 3*5 on the DOT_LEN=4 instance.
        drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd5);
        check("d4_prod", longint'(p0), 15);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'd3, 4'd5);
            check("d4_sum", longint'(s0), 15 * k);
            check("d4_noval", longint'(v0), 0);
        end
        idle();
        check("d4_sum60", longint'(s0), 60);
        check("d4_mac", longint'(m0), 60);
        check("d4_oval", longint'(v0), 1);
        check("d4_ovf", longint'(o0), 0);
        idle();
        check("d4_oval_drop", longint'(v0), 0);
        check("d4_mac_hold", longint'(m0), 60);

        // Same terms with random bubbles between them.
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k == 0, 1'b0, 4'd3, 4'd5);
            if (v0) pulses++;
            repeat ($urandom_range(1, 3)) begin
                idle();
                if (v0) pulses++;
            end
        end
        repeat (2) begin
            idle();
            if (v0) pulses++;
        end
        check("bub_pulses", longint'(pulses), 1);
        check("bub_mac", longint'(m0), 60);

        // Load on terms 1 and 3 abandons the first partial sum.
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, (k == 1) || (k == 3), 1'b0, 4'd2, 4'd2);
            if (v0) pulses++;
        end
        repeat (2) begin
            idle();
            if (v0) pulses++;
        end
        check("midld_pulses", longint'(pulses), 1);
        check("midld_mac", longint'(m0), 16);

        // Overflow on ACC_W=8, DOT_LEN=2, then a clean dot product.
        drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd15);
        drive(1'b1, 1'b0, 1'b0, 4'd15, 4'd15);
        idle();
`ifdef MAC_SAT_EN
        check("ovf_mac", longint'(m1), 255);
`else
        check("ovf_mac", longint'(m1), 194);
`endif
        check("ovf_flag", longint'(o1), 1);
        check("ovf_oval", longint'(v1), 1);
        drive(1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
        drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        idle();
        check("clean_mac", longint'(m1), 2);
        check("clean_ovf", longint'(o1), 0);

        // Signed product, then sclr mid dot product.
        drive(1'b1, 1'b1, 1'b0, 4'h8, 4'd7);
        check("sgn_prod", longint'(p2), 'hC8);
        drive(1'b1, 1'b0, 1'b0, 4'h8, 4'd7);
        check("sgn_sum", longint'(s2), 'hFC8);
        drive(1'b1, 1'b0, 1'b1, 4'h8, 4'd7);
        check("sclr_sum", longint'(s2), 0);
        check("sclr_oval", longint'(v2), 0);
        check("sclr_prod", longint'(p2), 0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
        idle();
        check("sclr_restart_mac", longint'(m2), 4);
        check("sclr_restart_oval", longint'(v2), 1);

        // Asynchronous reset in the middle of traffic.
        repeat (3) drive(1'b1, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
        in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge sys_clock);
        rst_n = 1'b1;

        // Random traffic against the model.
        repeat (2000) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) == 0, 4'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
